odo_job_loader: RTL

Parametrised successor to the host block-data loader. It accepts host words into header and target staging shift registers with per-field word counters. On `commit`, a complete job is atomically transferred to double-buffered active registers, while the hashing core keeps using the previous job until that transfer. It sits between the host command decoder and the odocrypt hashing pipeline, and adds completeness checking, job tagging and protocol-error flags.

---
 rtl/odo_job_pkg.sv | 18 +
 rtl/odo_word_stage.sv | 86 ++++++++
 rtl/odo_job_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/odo_job_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : odo_job_pkg
//  Purpose : Shared default geometry for the odocrypt job loader. The words
//            per field and the job tag width match the host block-data
//            format consumed by the hashing pipeline.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package odo_job_pkg;

    localparam int ODO_WORD_W    = 32;  // host word width
    localparam int ODO_HDR_WORDS = 19;  // 608-bit block header
    localparam int ODO_TGT_WORDS = 8;   // 256-bit target
    localparam int ODO_JOB_ID_W  = 4;   // job tag, wraps modulo 16

endpackage : odo_job_pkg
`default_nettype wire

// File: rtl/odo_word_stage.sv
`default_nettype none
// ============================================================================
//  Module  : odo_word_stage
//  Purpose : One staging field: a word-wide shift register with a saturating
//            word counter. SHIFT_UP=0 inserts at the MSW and shifts toward
//            word 0; SHIFT_UP=1 inserts at word 0 and shifts toward the MSW.
//  Ports   : clk, rst      - clock, synchronous active-high reset
//            din           - word to insert
//            we            - write request
//            clr           - clear the counter (contents left as they are)
//            blk           - suppress any write this cycle
//            data          - staged field, word 0 in the low bits
//            cnt           - words accepted since the last clear
//            full          - registered flag, cnt == WORDS
//            ovr           - write attempted while already full (event)
//  Rev     : 1.0  initial release
// ============================================================================
module odo_word_stage #(
    parameter int WORD_W   = 32,
    parameter int WORDS    = 8,
    parameter bit SHIFT_UP = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WORD_W-1:0]                din,
    input  logic                             we,
    input  logic                             clr,
    input  logic                             blk,
    output logic [WORDS*WORD_W-1:0]          data,
    output logic [$clog2(WORDS+1)-1:0]       cnt,
    output logic                             full,
    output logic                             ovr
);

    localparam int                 c_cnt_w   = $clog2(WORDS + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(WORDS);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [WORDS*WORD_W-1:0] r_data;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_full;
    logic [WORDS*WORD_W-1:0] w_shifted;
    logic [c_cnt_w-1:0]      w_cnt_nxt;
    logic                    w_accept;

    generate
        if (SHIFT_UP) begin : g_up
            assign w_shifted[WORD_W-1:0] = din;
            for (genvar i = 1; i < WORDS; i++) begin : g_word
                assign w_shifted[i*WORD_W +: WORD_W] = r_data[(i-1)*WORD_W +: WORD_W];
            end
        end else begin : g_down
            assign w_shifted[(WORDS-1)*WORD_W +: WORD_W] = din;
            for (genvar i = 0; i < WORDS - 1; i++) begin : g_word
                assign w_shifted[i*WORD_W +: WORD_W] = r_data[(i+1)*WORD_W +: WORD_W];
            end
        end
    endgenerate

    // A write against a full field is dropped entirely; blk masks both the
    // write and its overrun report, since the collision is flagged elsewhere.
    assign w_accept  = we & ~blk & ~r_full;
    assign w_cnt_nxt = r_cnt + c_cnt_one;
    assign ovr       = we & ~blk & r_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_data <= w_shifted;
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == c_cnt_max);
        end
    end

    assign data = r_data;
    assign cnt  = r_cnt;
    assign full = r_full;

endmodule : odo_word_stage
`default_nettype wire

// File: rtl/odo_job_loader.sv
`default_nettype none
// ============================================================================
//  Module  : odo_job_loader
//  Purpose : Stages host words into header/target fields and, on commit of a
//            complete stage, atomically moves them into the active job
//            registers seen by the hashing core. Tags jobs and keeps sticky
//            protocol error flags.
//  Ports   : clk_h, rst_h         - clock, synchronous active-high reset
//            data_in              - host word
//            hdr_we / tgt_we      - write header / target staging
//            commit / abort       - transfer / discard the stage
//            err_clr              - clear sticky error flags
//            header / target      - active job fields
//            job_id / job_valid   - active job tag / load pulse
//            staged_full          - both staging fields complete
//            err_overrun          - write to a full field (sticky)
//            err_incomplete       - commit on an incomplete stage (sticky)
//            err_protocol         - write together with commit/abort (sticky)
//  Rev     : 1.0  initial release
// ============================================================================
module odo_job_loader
    import odo_job_pkg::*;
#(
    parameter int WORD_W    = ODO_WORD_W,
    parameter int HDR_WORDS = ODO_HDR_WORDS,
    parameter int TGT_WORDS = ODO_TGT_WORDS,
    parameter int JOB_ID_W  = ODO_JOB_ID_W
) (
    input  logic                          clk_h,
    input  logic                          rst_h,
    input  logic [WORD_W-1:0]             data_in,
    input  logic                          hdr_we,
    input  logic                          tgt_we,
    input  logic                          commit,
    input  logic                          abort,
    input  logic                          err_clr,
    output logic [HDR_WORDS*WORD_W-1:0]   header,
    output logic [TGT_WORDS*WORD_W-1:0]   target,
    output logic [JOB_ID_W-1:0]           job_id,
    output logic                          job_valid,
    output logic                          staged_full,
    output logic                          err_overrun,
    output logic                          err_incomplete,
    output logic                          err_protocol
);

    localparam int                  c_hcnt_w = $clog2(HDR_WORDS + 1);
    localparam int                  c_tcnt_w = $clog2(TGT_WORDS + 1);
    localparam logic [c_hcnt_w-1:0] c_hmax   = c_hcnt_w'(HDR_WORDS);
    localparam logic [c_tcnt_w-1:0] c_tmax   = c_tcnt_w'(TGT_WORDS);
    localparam logic [JOB_ID_W-1:0] c_id_one = JOB_ID_W'(1);

    logic [HDR_WORDS*WORD_W-1:0] w_hdr_data;
    logic [TGT_WORDS*WORD_W-1:0] w_tgt_data;
    logic [c_hcnt_w-1:0]         w_hcnt;
    logic [c_tcnt_w-1:0]         w_tcnt;
    logic                        w_hdr_full, w_tgt_full;
    logic                        w_hdr_ovr, w_tgt_ovr;
    logic                        w_complete, w_do_commit, w_bad_commit;
    logic                        w_blk, w_clr, w_collide;

    logic [HDR_WORDS*WORD_W-1:0] r_header;
    logic [TGT_WORDS*WORD_W-1:0] r_target;
    logic [JOB_ID_W-1:0]         r_job_id;
    logic                        r_job_valid;
    logic                        r_err_ovr, r_err_inc, r_err_pro;

    // abort outranks commit, and either one swallows any write this cycle.
    assign w_complete   = (w_hcnt == c_hmax) && (w_tcnt == c_tmax);
    assign w_do_commit  = commit & ~abort & w_complete;
    assign w_bad_commit = commit & ~abort & ~w_complete;
    assign w_blk        = commit | abort;
    assign w_clr        = abort | w_do_commit;
    assign w_collide    = (hdr_we | tgt_we) & w_blk;

    odo_word_stage #(
        .WORD_W   (WORD_W),
        .WORDS    (HDR_WORDS),
        .SHIFT_UP (1'b0)
    ) u_hdr_stage (
        .clk  (clk_h),
        .rst  (rst_h),
        .din  (data_in),
        .we   (hdr_we),
        .clr  (w_clr),
        .blk  (w_blk),
        .data (w_hdr_data),
        .cnt  (w_hcnt),
        .full (w_hdr_full),
        .ovr  (w_hdr_ovr)
    );

    odo_word_stage #(
        .WORD_W   (WORD_W),
        .WORDS    (TGT_WORDS),
        .SHIFT_UP (1'b1)
    ) u_tgt_stage (
        .clk  (clk_h),
        .rst  (rst_h),
        .din  (data_in),
        .we   (tgt_we),
        .clr  (w_clr),
        .blk  (w_blk),
        .data (w_tgt_data),
        .cnt  (w_tcnt),
        .full (w_tgt_full),
        .ovr  (w_tgt_ovr)
    );

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            r_header    <= '0;
            r_target    <= '0;
            r_job_id    <= '0;
            r_job_valid <= 1'b0;
            r_err_ovr   <= 1'b0;
            r_err_inc   <= 1'b0;
            r_err_pro   <= 1'b0;
        end else begin
            r_job_valid <= w_do_commit;
            if (w_do_commit) begin
                r_header <= w_hdr_data;
                r_target <= w_tgt_data;
                r_job_id <= r_job_id + c_id_one;
            end
            // A fresh event in the clear cycle keeps its flag set.
            r_err_ovr <= (r_err_ovr & ~err_clr) | w_hdr_ovr | w_tgt_ovr;
            r_err_inc <= (r_err_inc & ~err_clr) | w_bad_commit;
            r_err_pro <= (r_err_pro & ~err_clr) | w_collide;
        end
    end

    assign header         = r_header;
    assign target         = r_target;
    assign job_id         = r_job_id;
    assign job_valid      = r_job_valid;
    assign staged_full    = w_hdr_full & w_tgt_full;
    assign err_overrun    = r_err_ovr;
    assign err_incomplete = r_err_inc;
    assign err_protocol   = r_err_pro;

endmodule : odo_job_loader
`default_nettype wire
